// File: rtl/keccak_pkg.sv
// -----------------------------------------------------------------------------
// keccak_pkg
//   Shared Keccak typedefs and constants.
//   - N            : lane width in bits
//   - lane/plane/state : state layout [y][x][z]
//   - chi_fsm_t    : control states of the iterative chi^-1 block
//   - CHI_INV_LUT  : 32-entry table of the 5-bit chi^-1 row function
//   - chi_inv5()   : table lookup wrapper, reused by any inverse-round block
// -----------------------------------------------------------------------------
package keccak_pkg;

    localparam int N = 64;

    typedef logic [N-1:0] lane;
    typedef lane  [4:0]   plane;   // indexed by x
    typedef plane [4:0]   state;   // indexed by y

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } chi_fsm_t;

    // Forward chi on one row: b_x = a_x ^ (~a_(x+1) & a_(x+2)).
    function automatic logic [4:0] chi5(input logic [4:0] a);
        logic [4:0] b;
        for (int x = 0; x < 5; x++) begin
            b[x] = a[x] ^ (~a[(x + 1) % 5] & a[(x + 2) % 5]);
        end
        return b;
    endfunction

    // chi is a permutation of the 32 row values, so inverting it by
    // scattering each input to the slot of its image fills every entry.
    function automatic logic [31:0][4:0] build_chi_inv_lut();
        logic [31:0][4:0] lut;
        lut = '0;
        for (int i = 0; i < 32; i++) begin
            lut[chi5(5'(i))] = 5'(i);
        end
        return lut;
    endfunction

    localparam logic [31:0][4:0] CHI_INV_LUT = build_chi_inv_lut();

    function automatic logic [4:0] chi_inv5(input logic [4:0] b);
        return CHI_INV_LUT[b];
    endfunction

endpackage

// File: rtl/chi_inv_plane.sv
// -----------------------------------------------------------------------------
// chi_inv_plane
//   Combinational chi^-1 over one plane: every z column of the plane forms a
//   5-bit row (bit x = lane x) that is replaced by chi_inv5 of itself.
// Ports
//   a : input plane  [x][z]
//   b : output plane [x][z]
// -----------------------------------------------------------------------------
module chi_inv_plane
    import keccak_pkg::*;
(
    input  plane a,
    output plane b
);

    for (genvar z = 0; z < N; z++) begin : g_row
        logic [4:0] row_inv;
        assign row_inv = chi_inv5({a[4][z], a[3][z], a[2][z], a[1][z], a[0][z]});
        assign {b[4][z], b[3][z], b[2][z], b[1][z], b[0][z]} = row_inv;
    end

endmodule

// File: rtl/chi_inv_iter.sv
// -----------------------------------------------------------------------------
// chi_inv_iter
//   Iterative inverse of the Keccak chi step. A state is captured over a
//   valid/ready handshake, PPC planes are inverted in place per cycle, and the
//   result is offered over a second valid/ready handshake.
// Parameters
//   PPC       : planes inverted per cycle (1 or 5); latency is 5/PPC cycles
// Ports
//   clk       : clock, rising edge
//   rst       : synchronous active-high reset
//   in_valid  : A_in holds a state to invert
//   in_ready  : block accepts A_in this cycle (combinational)
//   A_in      : input state [y][x][z]
//   out_valid : A_out holds the finished result
//   out_ready : consumer takes A_out this cycle
//   A_out     : working register; meaningful only with out_valid
// -----------------------------------------------------------------------------
module chi_inv_iter
    import keccak_pkg::*;
#(
    parameter int PPC = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    output logic in_ready,
    input  state A_in,
    output logic out_valid,
    input  logic out_ready,
    output state A_out
);

    if (PPC != 1 && PPC != 5) begin : g_bad_ppc
        $error("chi_inv_iter: PPC must be 1 or 5");
    end

    // Value of y_cnt when the planes being processed include plane 4.
    localparam logic [2:0] LAST_Y = 3'(5 - PPC);

    chi_fsm_t   st;
    logic [2:0] y_cnt;
    state       w;
    plane       inv [PPC];

    for (genvar p = 0; p < PPC; p++) begin : g_plane
        chi_inv_plane u_plane (
            .a (w[y_cnt + 3'(p)]),
            .b (inv[p])
        );
    end

    // NOTE: the working register is reset too, so A_out reads zero after reset
    // and an aborted transform leaves no stale data visible.
    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            out_valid <= 1'b0;
            y_cnt     <= '0;
            w         <= '0;
        end else begin
            // NOTE: non-blocking updates keep the muxed plane write-back and
            // the y_cnt advance both based on the pre-edge y_cnt.
            case (st)
                IDLE: begin
                    if (in_valid) begin
                        w     <= A_in;
                        y_cnt <= '0;
                        st    <= BUSY;
                    end
                end
                BUSY: begin
                    for (int p = 0; p < PPC; p++) begin
                        w[y_cnt + 3'(p)] <= inv[p];
                    end
                    if (y_cnt == LAST_Y) begin
                        y_cnt     <= '0;
                        out_valid <= 1'b1;
                        st        <= DONE;
                    end else begin
                        y_cnt <= y_cnt + 3'(PPC);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        if (in_valid) begin
                            w     <= A_in;
                            y_cnt <= '0;
                            st    <= BUSY;
                        end else begin
                            st <= IDLE;
                        end
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    // Accept a new state while idle, or in the same cycle the result leaves.
    assign in_ready = (st == IDLE) || (st == DONE && out_ready);
    assign A_out    = w;

endmodule

// File: tb/tb_chi_inv_iter.sv
module tb_chi_inv_iter;
    import keccak_pkg::*;

    logic clk = 1'b0;
    logic rst;
    logic in_valid  [2];
    logic in_ready  [2];
    logic out_valid [2];
    logic out_ready [2];
    state a_in      [2];
    state a_out     [2];

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    chi_inv_iter #(.PPC(1)) dut1 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .A_in      (a_in[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .A_out     (a_out[0])
    );

    chi_inv_iter #(.PPC(5)) dut5 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .A_in      (a_in[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .A_out     (a_out[1])
    );

    // Independent forward chi over a whole state.
    function automatic state chi_state(input state a);
        state b;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                b[y][x] = a[y][x] ^ (~a[y][(x + 1) % 5] & a[y][(x + 2) % 5]);
        return b;
    endfunction

    function automatic state rand_state();
        state s;
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                s[y][x] = N'({$urandom, $urandom});
        return s;
    endfunction

    // Prints one line locating the first differing lane of two states.
    task automatic report_state(input string name, input state act, input state exp);
        for (int y = 0; y < 5; y++)
            for (int x = 0; x < 5; x++)
                if (act[y][x] !== exp[y][x]) begin
                    $display("FAIL %s: lane y=%0d x=%0d got %h expected %h",
                             name, y, x, act[y][x], exp[y][x]);
                    return;
                end
        $display("FAIL %s: states differ", name);
    endtask

    // Offers s until accepted; returns at #1 after the accept edge.
    task automatic send(input int d, input state s);
        bit ok = 1'b0;
        a_in[d]     = s;
        in_valid[d] = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            if (in_ready[d]) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[d] = 1'b0;
        if (!ok) begin
            vectors++;
            miscompares++;
            $display("FAIL send_timeout: dut %0d never raised in_ready", d);
        end
    endtask

    // Counts edges from the accept edge until out_valid (bounded).
    task automatic wait_out(input int d, output int cyc);
        cyc = 0;
        while (!out_valid[d] && cyc < 20) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic run_check(input int d, input string name, input state s_in,
                             input state exp, input int exp_lat);
        int cyc;
        send(d, s_in);
        wait_out(d, cyc);
        vectors++;
        if (cyc !== exp_lat) begin
            miscompares++;
            $display("FAIL %s_latency: got %0d cycles expected %0d", name, cyc, exp_lat);
        end
        vectors++;
        if (a_out[d] !== exp) begin
            miscompares++;
            report_state(name, a_out[d], exp);
        end
        @(posedge clk);   // out_ready is high: result consumed here
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < 2; d++) begin
            vectors++;
            if (in_ready[d] !== 1'b1 || out_valid[d] !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_ctrl: dut %0d in_ready=%b out_valid=%b expected 1/0",
                         d, in_ready[d], out_valid[d]);
            end
            vectors++;
            if (a_out[d] !== '0) begin
                miscompares++;
                report_state("reset_a_out", a_out[d], '0);
            end
        end
    endtask

    task automatic test_zero();
        run_check(0, "zero_state", '0, '0, 5);
    endtask

    task automatic test_directed();
        state s, e;
        s = '0;
        e = '0;
        s[2][0][7] = 1'b1;   // row 0b01001: lanes 0 and 3
        s[2][3][7] = 1'b1;
        e[2][0][7] = 1'b1;
        run_check(0, "single_row", s, e, 5);
        run_check(0, "all_ones", '1, '1, 5);
        run_check(1, "all_ones_ppc5", '1, '1, 1);
    endtask

    task automatic test_random(input int d);
        state s;
        for (int i = 0; i < 200; i++) begin
            s = rand_state();
            run_check(d, (d == 0) ? "random_ppc1" : "random_ppc5",
                      chi_state(s), s, (d == 0) ? 5 : 1);
        end
    endtask

    task automatic test_hold_back_to_back();
        state s1, s2, held;
        int cyc;
        s1 = rand_state();
        s2 = rand_state();
        out_ready[0] = 1'b0;
        send(0, chi_state(s1));
        wait_out(0, cyc);
        held = a_out[0];
        vectors++;
        if (held !== s1) begin
            miscompares++;
            report_state("hold_result", held, s1);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            vectors++;
            if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || a_out[0] !== held) begin
                miscompares++;
                $display("FAIL hold_stable: cycle %0d out_valid=%b in_ready=%b a_out_same=%b expected 1/0/1",
                         i, out_valid[0], in_ready[0], a_out[0] === held);
            end
        end
        out_ready[0] = 1'b1;
        a_in[0]      = chi_state(s2);
        in_valid[0]  = 1'b1;
        #1;
        vectors++;
        if (in_ready[0] !== 1'b1) begin
            miscompares++;
            $display("FAIL b2b_in_ready: got %b expected 1", in_ready[0]);
        end
        @(posedge clk);
        #1;
        in_valid[0] = 1'b0;
        vectors++;
        if (out_valid[0] !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_busy: out_valid got %b expected 0", out_valid[0]);
        end
        wait_out(0, cyc);
        vectors++;
        if (cyc !== 5 || a_out[0] !== s2) begin
            miscompares++;
            $display("FAIL b2b_result: latency %0d (expected 5), data match %b",
                     cyc, a_out[0] === s2);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid();
        state s;
        s = rand_state();
        send(0, chi_state(s));
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        vectors++;
        if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || a_out[0] !== '0) begin
            miscompares++;
            $display("FAIL reset_mid: in_ready=%b out_valid=%b a_out_zero=%b expected 1/0/1",
                     in_ready[0], out_valid[0], a_out[0] === '0);
        end
        s = rand_state();
        run_check(0, "after_reset", chi_state(s), s, 5);
    endtask

    task automatic test_toggle_busy();
        state s;
        int results = 0;
        s = rand_state();
        send(0, chi_state(s));
        for (int i = 0; i < 4; i++) begin
            a_in[0]     = rand_state();
            in_valid[0] = i[0] ? 1'b0 : 1'b1;
            @(posedge clk);
            #1;
        end
        in_valid[0] = 1'b0;
        // Already at 4 edges after accept; one more edge raises out_valid.
        for (int i = 0; i < 15; i++) begin
            @(posedge clk);
            #1;
            if (out_valid[0]) begin
                results++;
                vectors++;
                if (a_out[0] !== s) begin
                    miscompares++;
                    report_state("toggle_result", a_out[0], s);
                end
            end
        end
        vectors++;
        if (results !== 1) begin
            miscompares++;
            $display("FAIL toggle_count: got %0d results expected 1", results);
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int d = 0; d < 2; d++) begin
            in_valid[d]  = 1'b0;
            out_ready[d] = 1'b1;
            a_in[d]      = '0;
        end
        test_reset();
        test_zero();
        test_directed();
        test_random(0);
        test_random(1);
        test_hold_back_to_back();
        test_reset_mid();
        test_toggle_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
